mmio_controller: RTL and testbench

MMIO_CONTROLLER -- requirements
Module: mmio_controller

---
 rtl/isa_types.sv | 47 ++++
 rtl/mmio_controller_fifo.sv | 67 ++++++
 rtl/mmio_controller.sv | 180 ++++++++++++++++++
 tb/tb_mmio_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_types.sv
// Shared hart/MMIO types: the request struct, the MMIO address map, the TX
// drain FSM states and the status register layout.
package isa_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    write_byte = 2'd0,
    write_half = 2'd1,
    write_word = 2'd2
  } mem_width_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    mem_width_t      width;
    logic            enable;
  } mem_write_control_t;

  localparam logic [XLEN-1:0] MMIO_UART_TX_ADDR = 32'h0003_0000;
  localparam logic [XLEN-1:0] MMIO_LED_BLUE_ADDR = 32'h0003_0004;
  localparam logic [XLEN-1:0] MMIO_LED_GREEN_ADDR = 32'h0003_0008;
  localparam logic [XLEN-1:0] MMIO_STATUS_ADDR = 32'h0003_000C;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_OFFER = 2'd1,
    TX_BUSY  = 2'd2
  } tx_state_t;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT = 2;
  localparam int unsigned STATUS_COUNT_LSB = 3;

  function automatic logic [XLEN-1:0] pack_status(input logic [4:0] count, input logic busy,
                                                  input logic full, input logic empty);
    logic [XLEN-1:0] s;
    s = '0;
    s[STATUS_EMPTY_BIT] = empty;
    s[STATUS_FULL_BIT] = full;
    s[STATUS_BUSY_BIT] = busy;
    s[STATUS_COUNT_LSB +: 5] = count;
    return s;
  endfunction

endpackage

// File: rtl/mmio_controller_fifo.sv
// byte_fifo: small circular byte queue for the UART TX path. Only present
// when MMIO_TX_FIFO_EN is defined. DEPTH must be a power of two.
`ifdef MMIO_TX_FIFO_EN
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic [4:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [7:0]       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full = (count_q == 5'(DEPTH));
    empty = (count_q == '0);
    do_push = push && !full;
    do_pop = pop && !empty;
    mem_d = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 5'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 5'd1;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/mmio_controller.sv
// MMIO block: UART TX path, two LED registers and a status register.
// Define MMIO_TX_FIFO_EN to put a byte_fifo between the hart and the TX FSM.
module mmio_controller
  import isa_types::*;
#(
  parameter int unsigned TX_FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  mem_write_control_t mmio_control,
  output logic               mmio_write_complete,
  output logic [XLEN-1:0]    mmio_r_data,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_data_available,
  output logic               led_blue_control,
  output logic               led_green_control
);

  if (TX_FIFO_DEPTH < 2 || TX_FIFO_DEPTH > 16 ||
      (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("TX_FIFO_DEPTH must be a power of two in 2..16");
  end

  // Reset asserts immediately but releases two edges after reset_n rises.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n_int = rst_sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else rst_sync_q <= rst_sync_d;
  end

  logic       is_uart, is_blue, is_green, is_status, uart_byte, req_new, complete_now;
  logic       accepted_q, accepted_d;
  logic       led_blue_q, led_blue_d, led_green_q, led_green_d;
  tx_state_t  state_q, state_d;
  logic [7:0] offer_q, offer_d, tx_data_q, tx_data_d;
  logic       avail_q, avail_d;
  logic [4:0] stat_count;
  logic       stat_full, stat_empty, tx_busy;

`ifdef MMIO_TX_FIFO_EN
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic [4:0] fifo_count;

  byte_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk      (clock),
    .rst_n    (rst_n_int),
    .push     (fifo_push),
    .push_data(mmio_control.value[7:0]),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );
`else
  logic load_direct, loaded_q, loaded_d;
`endif

  always_comb begin
    is_uart = (mmio_control.addr == MMIO_UART_TX_ADDR);
    is_blue = (mmio_control.addr == MMIO_LED_BLUE_ADDR);
    is_green = (mmio_control.addr == MMIO_LED_GREEN_ADDR);
    is_status = (mmio_control.addr == MMIO_STATUS_ADDR);
    uart_byte = is_uart && (mmio_control.width == write_byte);
    req_new = mmio_control.enable && !accepted_q && rst_n_int;
    complete_now = 1'b0;
`ifdef MMIO_TX_FIFO_EN
    fifo_push = 1'b0;
`else
    load_direct = 1'b0;
`endif
    if (req_new) begin
      if (uart_byte) begin
`ifdef MMIO_TX_FIFO_EN
        if (!fifo_full) begin
          complete_now = 1'b1;
          fifo_push = 1'b1;
        end
`else
        // Without a FIFO the hart is held until its own byte reaches TX_BUSY.
        if (loaded_q && state_q == TX_BUSY) complete_now = 1'b1;
        else if (!loaded_q && state_q == TX_IDLE) load_direct = 1'b1;
`endif
      end else begin
        complete_now = 1'b1;
      end
    end
    accepted_d = mmio_control.enable && (accepted_q || complete_now);
`ifndef MMIO_TX_FIFO_EN
    loaded_d = mmio_control.enable && !complete_now && (loaded_q || load_direct);
`endif
    led_blue_d = led_blue_q;
    led_green_d = led_green_q;
    if (req_new && is_blue) led_blue_d = |mmio_control.value;
    if (req_new && is_green) led_green_d = |mmio_control.value;
    mmio_write_complete = accepted_d;
  end

  always_comb begin
    state_d = state_q;
    offer_d = offer_q;
`ifdef MMIO_TX_FIFO_EN
    fifo_pop = 1'b0;
`endif
    unique case (state_q)
      TX_IDLE: begin
`ifdef MMIO_TX_FIFO_EN
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          offer_d = fifo_rdata;
          state_d = TX_OFFER;
        end
`else
        if (load_direct) begin
          offer_d = mmio_control.value[7:0];
          state_d = TX_OFFER;
        end
`endif
      end
      TX_OFFER: if (!tx_ready) state_d = TX_BUSY;
      TX_BUSY:  if (tx_ready) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
    avail_d = (state_d == TX_OFFER);
    tx_data_d = avail_d ? offer_d : '0;
  end

  always_comb begin
    tx_busy = (state_q != TX_IDLE);
`ifdef MMIO_TX_FIFO_EN
    stat_count = fifo_count;
    stat_full = fifo_full;
    stat_empty = fifo_empty;
`else
    stat_count = '0;
    stat_full = tx_busy;
    stat_empty = 1'b1;
`endif
    mmio_r_data = is_status ? pack_status(stat_count, tx_busy, stat_full, stat_empty) : '0;
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      accepted_q <= 1'b0;
      led_blue_q <= 1'b0;
      led_green_q <= 1'b0;
      state_q <= TX_IDLE;
      offer_q <= '0;
      avail_q <= 1'b0;
      tx_data_q <= '0;
`ifndef MMIO_TX_FIFO_EN
      loaded_q <= 1'b0;
`endif
    end else begin
      accepted_q <= accepted_d;
      led_blue_q <= led_blue_d;
      led_green_q <= led_green_d;
      state_q <= state_d;
      offer_q <= offer_d;
      avail_q <= avail_d;
      tx_data_q <= tx_data_d;
`ifndef MMIO_TX_FIFO_EN
      loaded_q <= loaded_d;
`endif
    end
  end

  assign tx_data_available = avail_q;
  assign tx_data = tx_data_q;
  assign led_blue_control = led_blue_q;
  assign led_green_control = led_green_q;

endmodule

// File: tb/tb_mmio_controller.sv
// Scoreboard bench for mmio_controller: expected TX bytes are queued by the
// hart stimulus and checked by a transmitter-model monitor.
module tb_mmio_controller;
  import isa_types::*;

`ifdef MMIO_TX_FIFO_EN
  localparam int          UART_STALL = 0;
  localparam logic [31:0] BUSY_STATUS = 32'h5;
  localparam logic [31:0] OFFER_STATUS = 32'h1C;
`else
  localparam int          UART_STALL = 2;
  localparam logic [31:0] BUSY_STATUS = 32'h7;
  localparam logic [31:0] OFFER_STATUS = 32'h7;
`endif

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  mem_write_control_t ctl;
  logic               complete;
  logic [31:0]        rdata;
  logic               tx_ready = 1'b1;
  logic [7:0]         tx_data;
  logic               avail, led_b, led_g;

  int         ncmp = 0;
  int         nfail = 0;
  logic [7:0] exp_q[$];
  logic       tx_pause = 1'b1;
  int         tx_hold = 1;
  int         busy_left = 0;
  int         st;

  always #5 clock = ~clock;

  mmio_controller #(.TX_FIFO_DEPTH(4)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .mmio_control       (ctl),
    .mmio_write_complete(complete),
    .mmio_r_data        (rdata),
    .tx_ready           (tx_ready),
    .tx_data            (tx_data),
    .tx_data_available  (avail),
    .led_blue_control   (led_b),
    .led_green_control  (led_g)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Transmitter model: takes the offered byte, then holds tx_ready low for tx_hold cycles.
  always @(negedge clock) begin
    if (busy_left > 0) begin
      check("busy_avail_low", 32'(avail), 32'h0);
      check("idle_data_zero", 32'(tx_data), 32'h0);
      busy_left--;
      if (busy_left == 0) tx_ready = 1'b1;
    end else if (avail && !tx_pause) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_byte: actual 0x%02h required none", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      tx_ready = 1'b0;
      busy_left = tx_hold;
    end
  end

  task automatic hart_write(input logic [31:0] addr, input logic [31:0] value,
                            input mem_width_t w, output int stall);
    ctl.addr = addr;
    ctl.value = value;
    ctl.width = w;
    ctl.enable = 1'b1;
    stall = 0;
    #1;
    while (!complete && stall < 200) begin
      @(negedge clock);
      #1;
      stall++;
    end
    if (!complete) begin
      ncmp++;
      nfail++;
      $display("FAIL write_timeout: actual no complete required complete addr 0x%08h", addr);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drop_req();
    @(negedge clock);
    ctl.enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    ctl = '0;
    ctl.width = write_word;
    #1 reset_n = 1'b0;
    #6;
    ctl.addr = MMIO_STATUS_ADDR;
    #1;
    check("rst_complete", 32'(complete), 32'h0);
    check("rst_avail", 32'(avail), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_led_blue", 32'(led_b), 32'h0);
    check("rst_led_green", 32'(led_g), 32'h0);
    check("rst_status", rdata, 32'h1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    tx_pause = 1'b0;

    // Blue LED: one update despite holding enable and changing value.
    hart_write(MMIO_LED_BLUE_ADDR, 32'd5, write_word, st);
    check("blue_stall", 32'(st), 32'h0);
    check("blue_led", 32'(led_b), 32'h1);
    @(negedge clock);
    ctl.value = '0;
    #1 check("blue_hold_complete", 32'(complete), 32'h1);
    @(posedge clock);
    #1 check("blue_no_rewrite", 32'(led_b), 32'h1);
    drop_req();
    #1 check("complete_drops", 32'(complete), 32'h0);
    @(posedge clock);
    #1 check("blue_kept", 32'(led_b), 32'h1);

    @(negedge clock);
    hart_write(MMIO_LED_GREEN_ADDR, 32'h0, write_word, st);
    check("green_zero", 32'(led_g), 32'h0);
    drop_req();
    @(negedge clock);
    hart_write(MMIO_LED_GREEN_ADDR, 32'h100, write_word, st);
    check("green_upper_bits", 32'(led_g), 32'h1);
    drop_req();
    @(negedge clock);
    hart_write(MMIO_LED_BLUE_ADDR, 32'h0, write_byte, st);
    check("blue_clear", 32'(led_b), 32'h0);
    drop_req();

    // Discarded writes: UART halfword, unmapped, status.
    @(negedge clock);
    hart_write(MMIO_UART_TX_ADDR, 32'h1234, write_half, st);
    check("half_stall", 32'(st), 32'h0);
    drop_req();
    @(negedge clock);
    hart_write(32'h0003_0010, 32'h7, write_byte, st);
    check("unmapped_stall", 32'(st), 32'h0);
    drop_req();
    @(negedge clock);
    hart_write(MMIO_STATUS_ADDR, 32'hFF, write_byte, st);
    check("status_write_stall", 32'(st), 32'h0);
    drop_req();
    ctl.addr = MMIO_STATUS_ADDR;
    for (int i = 0; i < 4; i++) begin
      #1 check("discard_no_tx", 32'(avail), 32'h0);
      check("discard_status", rdata, 32'h1);
      @(negedge clock);
    end

    // Short burst with a responsive transmitter.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h61 + 8'(i));
      hart_write(MMIO_UART_TX_ADDR, 32'h61 + 32'(i), write_byte, st);
      check("burst_stall", 32'(st), 32'(UART_STALL));
      drop_req();
      @(negedge clock);
    end
    repeat (6) @(negedge clock);

    // Long transmitter busy period.
    tx_hold = 10;
    exp_q.push_back(8'h42);
    hart_write(MMIO_UART_TX_ADDR, 32'h42, write_byte, st);
    check("long_stall", 32'(st), 32'(UART_STALL));
    drop_req();
    ctl.addr = MMIO_STATUS_ADDR;
`ifdef MMIO_TX_FIFO_EN
    repeat (2) @(negedge clock);
`endif
    #1 check("busy_status", rdata, BUSY_STATUS);
    repeat (12) @(negedge clock);
    #1 check("drained_status", rdata, 32'h1);
    tx_hold = 1;

`ifdef MMIO_TX_FIFO_EN
    // Fill the FIFO behind a stalled offer, then release the transmitter.
    tx_pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      exp_q.push_back(8'h41 + 8'(i));
      hart_write(MMIO_UART_TX_ADDR, 32'h41 + 32'(i), write_byte, st);
      check("fill_stall", 32'(st), 32'h0);
      drop_req();
    end
    ctl.addr = MMIO_STATUS_ADDR;
    #1 check("full_status", rdata, 32'h26);
    tx_pause = 1'b0;
    @(negedge clock);
    exp_q.push_back(8'h46);
    hart_write(MMIO_UART_TX_ADDR, 32'h46, write_byte, st);
    check("sixth_stalls", 32'(st > 0), 32'h1);
    drop_req();
    for (int w = 0; w < 300 && (exp_q.size() != 0 || busy_left != 0); w++) @(negedge clock);
    repeat (3) @(negedge clock);
`endif

    // Reset while a byte is on offer.
    @(negedge clock);
    hart_write(MMIO_LED_BLUE_ADDR, 32'h1, write_word, st);
    drop_req();
    tx_pause = 1'b1;
`ifdef MMIO_TX_FIFO_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      hart_write(MMIO_UART_TX_ADDR, 32'h55 + 32'(i), write_byte, st);
      drop_req();
    end
`else
    @(negedge clock);
    ctl.addr = MMIO_UART_TX_ADDR;
    ctl.value = 32'h55;
    ctl.width = write_byte;
    ctl.enable = 1'b1;
    drop_req();
`endif
    @(negedge clock);
    ctl.addr = MMIO_STATUS_ADDR;
    #1;
    check("offer_avail", 32'(avail), 32'h1);
    check("offer_data", 32'(tx_data), 32'h55);
    check("offer_status", rdata, OFFER_STATUS);
    #2 reset_n = 1'b0;
    #1;
    check("async_avail", 32'(avail), 32'h0);
    check("async_tx_data", 32'(tx_data), 32'h0);
    check("async_led_blue", 32'(led_b), 32'h0);
    check("async_status", rdata, 32'h1);

    // Release: two edges pass before the blue write is honoured.
    @(negedge clock);
    reset_n = 1'b1;
    ctl.addr = MMIO_LED_BLUE_ADDR;
    ctl.value = 32'h1;
    ctl.width = write_word;
    ctl.enable = 1'b1;
    #1 check("sync_hold_complete", 32'(complete), 32'h0);
    @(posedge clock);
    #1 check("sync_edge1_complete", 32'(complete), 32'h0);
    @(posedge clock);
    #1 check("sync_edge2_complete", 32'(complete), 32'h1);
    check("sync_edge2_led", 32'(led_b), 32'h0);
    @(posedge clock);
    #1 check("sync_edge3_led", 32'(led_b), 32'h1);
    drop_req();
    ctl.addr = MMIO_STATUS_ADDR;
    tx_pause = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    check("no_retry_avail", 32'(avail), 32'h0);
    check("no_retry_status", rdata, 32'h1);

    for (int w = 0; w < 500 && (exp_q.size() != 0 || busy_left != 0); w++) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
